// File: rtl/boxcar_pkg.sv
// boxcar_pkg: shared sizing helpers and window-select decode for the boxcar averager
package boxcar_pkg;
  localparam int DEF_BIT_WIDTH = 32;
  localparam int DEF_LOG2_MAX_DEPTH = 4;
  localparam int DEF_SEL_W = 3;
  function automatic int acc_width(input int bw, input int l2);
    return bw + l2;
  endfunction
  function automatic int ptr_width(input int l2);
    return l2;
  endfunction
  function automatic int cnt_width(input int l2);
    return l2 + 1;
  endfunction
  function automatic int sel_to_k(input int sel, input int l2);
    return (sel > l2) ? l2 : sel;
  endfunction
endpackage

// File: rtl/boxcar_avg_if.sv
// boxcar_avg_if: sample stream in, average stream out, plus synchronous clear and window select
interface boxcar_avg_if #(
  parameter int BIT_WIDTH = 32,
  parameter int SEL_W = 3
);
  logic sclr;
  logic [SEL_W-1:0] filt_sel;
  logic in_valid;
  logic signed [BIT_WIDTH-1:0] d;
  logic out_valid;
  logic signed [BIT_WIDTH-1:0] q;
  modport master(output sclr, filt_sel, in_valid, d, input out_valid, q);
  modport slave(input sclr, filt_sel, in_valid, d, output out_valid, q);
endinterface

// File: rtl/boxcar_avg_sample_ring.sv
// sample_ring: circular sample history with a combinational read n entries behind the write pointer
module sample_ring
  import boxcar_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int LOG2_MAX_DEPTH = DEF_LOG2_MAX_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic we,
  input  logic [BIT_WIDTH-1:0] wd,
  input  logic [LOG2_MAX_DEPTH-1:0] off,
  output logic [BIT_WIDTH-1:0] old
);
  localparam int PTR_W = ptr_width(LOG2_MAX_DEPTH);
  localparam int DEPTH = 1 << LOG2_MAX_DEPTH;
  logic [BIT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  assign old = mem[wr_ptr - off];
  // write pointer advances once per accepted sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wr_ptr <= '0;
    else if (clr) wr_ptr <= '0;
    else if (we) wr_ptr <= wr_ptr + PTR_W'(1);
  // storage carries no reset; stale entries are never subtracted before a window refills
  always_ff @(posedge clk)
    if (we) mem[wr_ptr] <= wd;
endmodule

// File: rtl/boxcar_avg.sv
// boxcar_avg: running-sum moving average of the last 2^k samples; define ROUND_EN for round-half-up output
module boxcar_avg
  import boxcar_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int LOG2_MAX_DEPTH = DEF_LOG2_MAX_DEPTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input logic clk,
  input logic rst_n,
  boxcar_avg_if.slave bus
);
  localparam int ACC_W = acc_width(BIT_WIDTH, LOG2_MAX_DEPTH);
  localparam int CNT_W = cnt_width(LOG2_MAX_DEPTH);
  localparam logic [CNT_W-1:0] MAX_DEPTH = CNT_W'(1) << LOG2_MAX_DEPTH;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] k, sel_q, n, fill_cnt, fill_nxt;
  logic flush, full, accept, out_valid;
  logic signed [ACC_W-1:0] acc, d_ext, old_ext, sum, rnd;
  logic [BIT_WIDTH-1:0] old;
  logic signed [BIT_WIDTH-1:0] q, q_nxt;
  assign sel = bus.filt_sel;
  assign k = CNT_W'(sel_to_k(int'(sel), LOG2_MAX_DEPTH));
  assign n = CNT_W'(1) << k;
  assign accept = bus.in_valid && !bus.sclr;
  assign bus.out_valid = out_valid;
  assign bus.q = q;
  sample_ring #(
    .BIT_WIDTH(BIT_WIDTH),
    .LOG2_MAX_DEPTH(LOG2_MAX_DEPTH)
  ) ring (
    .clk(clk),
    .rst_n(rst_n),
    .clr(bus.sclr),
    .we(accept),
    .wd(bus.d),
    .off(n[LOG2_MAX_DEPTH-1:0]),
    .old(old)
  );
  // next accumulator, fill count and scaled average for a sample arriving this cycle
  always_comb begin
    flush = k != sel_q;
    full = fill_cnt >= n;
    d_ext = {{LOG2_MAX_DEPTH{bus.d[BIT_WIDTH-1]}}, bus.d};
    old_ext = {{LOG2_MAX_DEPTH{old[BIT_WIDTH-1]}}, old};
    sum = flush ? d_ext : full ? acc + d_ext - old_ext : acc + d_ext;
    fill_nxt = flush ? CNT_W'(1) : (fill_cnt == MAX_DEPTH) ? fill_cnt : fill_cnt + CNT_W'(1);
`ifdef ROUND_EN
    rnd = ACC_W'((ACC_W'(1) << k) >> 1);
`else
    rnd = '0;
`endif
    q_nxt = BIT_WIDTH'((sum + rnd) >>> k);
  end
  // state: async reset, then sclr, then accept / window flush / hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      fill_cnt <= '0;
      sel_q <= '0;
      out_valid <= 1'b0;
      q <= '0;
    end else if (bus.sclr) begin
      acc <= '0;
      fill_cnt <= '0;
      sel_q <= '0;
      out_valid <= 1'b0;
      q <= '0;
    end else begin
      sel_q <= k;
      out_valid <= bus.in_valid && fill_nxt >= n;
      if (bus.in_valid) begin
        acc <= sum;
        fill_cnt <= fill_nxt;
        if (fill_nxt >= n) q <= q_nxt;
      end else if (flush) begin
        acc <= '0;
        fill_cnt <= '0;
      end
    end
endmodule
